// File: rtl/mvm_job_scheduler.sv
// Job scheduler for the NxN matrix-vector engine.
// Buffers host job descriptors in a small FIFO, runs each job as
// (optional accumulator clear) -> start -> wait for done under a cycle
// watchdog, and hands back one completion record per job.
module mvm_job_scheduler #(
    parameter int ADDR_W  = 8,
    parameter int ID_W    = 4,
    parameter int QDEPTH  = 4,
    parameter int CYC_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [ID_W-1:0]            job_id,
    input  logic [ADDR_W-1:0]          job_w_base,
    input  logic [ADDR_W-1:0]          job_x_base,
    input  logic                       job_clear,
    input  logic                       abort,
    output logic                       eng_clear,
    output logic                       eng_start,
    output logic [ADDR_W-1:0]          eng_w_base,
    output logic [ADDR_W-1:0]          eng_x_base,
    input  logic                       eng_busy,
    input  logic                       eng_done,
    output logic                       cmp_valid,
    input  logic                       cmp_ready,
    output logic [ID_W-1:0]            cmp_id,
    output logic [1:0]                 cmp_status,
    output logic [CYC_W-1:0]           cmp_cycles,
    output logic [$clog2(QDEPTH):0]    q_level,
    output logic                       idle
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(QDEPTH);
    localparam logic [CYC_W-1:0] TIMEOUT_C = CYC_W'(TIMEOUT);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ABORTED = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_RUN,
        S_REPORT
    } state_t;

    state_t state;

    logic [ID_W-1:0]   fifo_id  [QDEPTH];
    logic [ADDR_W-1:0] fifo_w   [QDEPTH];
    logic [ADDR_W-1:0] fifo_x   [QDEPTH];
    logic              fifo_clr [QDEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;
    logic [ID_W-1:0]   cur_id;
    logic [CYC_W-1:0]  counter;
    logic [CYC_W-1:0]  cnt_next;
    logic              push;
    logic              pop;
    logic              abort_job;

    // job_ready looks only at occupancy, so a full FIFO never passes a
    // descriptor straight through even when a pop happens the same cycle.
    assign job_ready = (count != FULL_LVL);
    assign q_level   = count;
    assign idle      = (state == S_IDLE) && (count == '0);
    assign push      = job_valid && job_ready && !abort;
    assign pop       = (state == S_IDLE) && (count != '0) && !eng_busy
                       && !cmp_valid && !abort;
    assign abort_job = abort && ((state == S_CLEAR) || (state == S_LAUNCH)
                                 || (state == S_RUN));
    assign cnt_next  = counter + 1'b1;

    // Descriptor storage: data only, written on push, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr]  <= job_id;
            fifo_w[wr_ptr]   <= job_w_base;
            fifo_x[wr_ptr]   <= job_x_base;
            fifo_clr[wr_ptr] <= job_clear;
        end
    end

    // FIFO pointers and occupancy; abort empties the queue and drops any push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // Job sequencer with registered engine strobes and completion record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            eng_clear  <= 1'b0;
            eng_start  <= 1'b0;
            eng_w_base <= '0;
            eng_x_base <= '0;
            cmp_valid  <= 1'b0;
            cmp_id     <= '0;
            cmp_status <= '0;
            cmp_cycles <= '0;
            cur_id     <= '0;
            counter    <= '0;
        end else begin
            eng_clear <= 1'b0;
            eng_start <= 1'b0;
            if (abort_job) begin
                state      <= S_REPORT;
                cmp_valid  <= 1'b1;
                cmp_id     <= cur_id;
                cmp_status <= ST_ABORTED;
                cmp_cycles <= counter;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (pop) begin
                            cur_id     <= fifo_id[rd_ptr];
                            eng_w_base <= fifo_w[rd_ptr];
                            eng_x_base <= fifo_x[rd_ptr];
                            counter    <= '0;
                            if (fifo_clr[rd_ptr]) begin
                                state     <= S_CLEAR;
                                eng_clear <= 1'b1;
                            end else begin
                                state     <= S_LAUNCH;
                                eng_start <= 1'b1;
                            end
                        end
                    end
                    S_CLEAR: begin
                        state     <= S_LAUNCH;
                        eng_start <= 1'b1;
                    end
                    S_LAUNCH: begin
                        state   <= S_RUN;
                        counter <= '0;
                    end
                    S_RUN: begin
                        // Done takes priority over a watchdog expiring on the same cycle.
                        if (eng_done) begin
                            state      <= S_REPORT;
                            cmp_valid  <= 1'b1;
                            cmp_id     <= cur_id;
                            cmp_status <= ST_OK;
                            cmp_cycles <= cnt_next;
                        end else if (cnt_next == TIMEOUT_C) begin
                            state      <= S_REPORT;
                            cmp_valid  <= 1'b1;
                            cmp_id     <= cur_id;
                            cmp_status <= ST_TIMEOUT;
                            cmp_cycles <= TIMEOUT_C;
                        end else begin
                            counter <= cnt_next;
                        end
                    end
                    S_REPORT: begin
                        if (cmp_ready) begin
                            state     <= S_IDLE;
                            cmp_valid <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mvm_job_scheduler.sv
// Directed bench for mvm_job_scheduler. Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_mvm_job_scheduler;

    localparam int ADDR_W  = 8;
    localparam int ID_W    = 4;
    localparam int QDEPTH  = 4;
    localparam int CYC_W   = 16;
    localparam int TIMEOUT = 1000;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    job_valid;
    logic                    job_ready;
    logic [ID_W-1:0]         job_id;
    logic [ADDR_W-1:0]       job_w_base;
    logic [ADDR_W-1:0]       job_x_base;
    logic                    job_clear;
    logic                    abort;
    logic                    eng_clear;
    logic                    eng_start;
    logic [ADDR_W-1:0]       eng_w_base;
    logic [ADDR_W-1:0]       eng_x_base;
    logic                    eng_busy;
    logic                    eng_done;
    logic                    cmp_valid;
    logic                    cmp_ready;
    logic [ID_W-1:0]         cmp_id;
    logic [1:0]              cmp_status;
    logic [CYC_W-1:0]        cmp_cycles;
    logic [$clog2(QDEPTH):0] q_level;
    logic                    idle;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mvm_job_scheduler #(
        .ADDR_W(ADDR_W), .ID_W(ID_W), .QDEPTH(QDEPTH),
        .CYC_W(CYC_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
        .job_w_base(job_w_base), .job_x_base(job_x_base), .job_clear(job_clear),
        .abort(abort),
        .eng_clear(eng_clear), .eng_start(eng_start),
        .eng_w_base(eng_w_base), .eng_x_base(eng_x_base),
        .eng_busy(eng_busy), .eng_done(eng_done),
        .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_id(cmp_id),
        .cmp_status(cmp_status), .cmp_cycles(cmp_cycles),
        .q_level(q_level), .idle(idle)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [3:0] id, input logic [7:0] w, input logic [7:0] x,
                        input logic clr);
        job_valid  = 1'b1;
        job_id     = id;
        job_w_base = w;
        job_x_base = x;
        job_clear  = clr;
        tick();
        job_valid  = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (eng_start !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(eng_start), 32'd1);
    endtask

    task automatic check_cmp(input string tag, input logic [3:0] id, input logic [1:0] st,
                             input logic [15:0] cyc);
        check({tag, "_valid"},  32'(cmp_valid),  32'd1);
        check({tag, "_id"},     32'(cmp_id),     32'(id));
        check({tag, "_status"}, 32'(cmp_status), 32'(st));
        check({tag, "_cycles"}, 32'(cmp_cycles), 32'(cyc));
    endtask

    task automatic accept(input string tag);
        cmp_ready = 1'b1;
        tick();
        cmp_ready = 1'b0;
        check(tag, 32'(cmp_valid), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; job_valid = 1'b0; job_id = '0; job_w_base = '0; job_x_base = '0;
        job_clear = 1'b0; abort = 1'b0; eng_busy = 1'b0; eng_done = 1'b0; cmp_ready = 1'b0;
        tick(); tick();
        check("rst_job_ready", 32'(job_ready), 32'd1);
        check("rst_idle",      32'(idle),      32'd1);
        check("rst_q_level",   32'(q_level),   32'd0);
        check("rst_cmp_valid", 32'(cmp_valid), 32'd0);
        check("rst_strobes",   32'({eng_clear, eng_start}), 32'd0);
        rst = 1'b0;
        tick();

        // Job with clear: CLEAR after E1, LAUNCH after E2, done 9 cycles after start.
        push(4'd3, 8'h10, 8'h20, 1'b1);
        check("t1_q_after_push", 32'(q_level),   32'd1);
        check("t1_clear_E0",     32'(eng_clear), 32'd0);
        tick();
        check("t1_clear_E1",     32'(eng_clear), 32'd1);
        check("t1_start_E1",     32'(eng_start), 32'd0);
        check("t1_q_after_pop",  32'(q_level),   32'd0);
        tick();
        check("t1_start_E2",     32'(eng_start), 32'd1);
        check("t1_clear_E2",     32'(eng_clear), 32'd0);
        check("t1_w_base",       32'(eng_w_base), 32'h10);
        check("t1_x_base",       32'(eng_x_base), 32'h20);
        repeat (9) tick();
        check("t1_no_cmp_yet",   32'(cmp_valid), 32'd0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check_cmp("t1_cmp", 4'd3, 2'b00, 16'd9);
        accept("t1_accept");
        check("t1_idle", 32'(idle), 32'd1);

        // Five back-to-back pushes against a stalled engine.
        eng_busy = 1'b1;
        push(4'd1, 8'h11, 8'h21, 1'b0);
        push(4'd2, 8'h12, 8'h22, 1'b0);
        push(4'd4, 8'h14, 8'h24, 1'b0);
        push(4'd5, 8'h15, 8'h25, 1'b0);
        check("t2_q_full",       32'(q_level),   32'd4);
        check("t2_ready_low",    32'(job_ready), 32'd0);
        job_valid = 1'b1; job_id = 4'd6; job_w_base = 8'h16; job_x_base = 8'h26; job_clear = 1'b0;
        tick();
        check("t2_fifth_held",   32'(q_level),   32'd4);
        eng_busy = 1'b0;
        tick();
        check("t2_q_after_pop",  32'(q_level),   32'd3);
        check("t2_ready_back",   32'(job_ready), 32'd1);
        check("t2_start",        32'(eng_start), 32'd1);
        check("t2_no_clear",     32'(eng_clear), 32'd0);
        check("t2_w_base",       32'(eng_w_base), 32'h11);
        tick();
        job_valid = 1'b0;
        check("t2_fifth_in",     32'(q_level),   32'd4);
        tick(); tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check_cmp("t2_cmp", 4'd1, 2'b00, 16'd3);

        // Completion back-pressure holds the record and blocks new launches.
        for (int i = 0; i < 20; i++) begin
            check("t4_hold", 32'({eng_start, cmp_valid, cmp_id, cmp_status, cmp_cycles}),
                  32'({1'b0, 1'b1, 4'd1, 2'b00, 16'd3}));
            check("t4_q_hold", 32'(q_level), 32'd4);
            tick();
        end
        accept("t4_accept");
        tick();
        check("t4_launch_after", 32'(eng_start), 32'd1);
        check("t4_w_base",       32'(eng_w_base), 32'h12);
        check("t4_q_level",      32'(q_level),   32'd3);

        // Watchdog: engine stays busy and never signals done.
        eng_busy = 1'b1;
        n = 0;
        while (cmp_valid !== 1'b1 && n < 1100) begin
            tick();
            n++;
        end
        check("t3_elapsed", 32'(n), 32'd1001);
        check_cmp("t3_cmp", 4'd2, 2'b01, 16'd1000);
        accept("t3_accept");
        for (int i = 0; i < 5; i++) begin
            check("t3_no_launch_busy", 32'({eng_start, eng_clear}), 32'd0);
            check("t3_q_kept",         32'(q_level), 32'd3);
            tick();
        end
        eng_busy = 1'b0;
        tick();
        check("t3_launch_free", 32'(eng_start),  32'd1);
        check("t3_w_base",      32'(eng_w_base), 32'h14);
        check("t3_x_base",      32'(eng_x_base), 32'h24);

        // Abort in RUN at counter 5 with three jobs queued; same-cycle push is dropped.
        push(4'd7, 8'h17, 8'h27, 1'b0);
        check("t5_q_three", 32'(q_level), 32'd3);
        repeat (5) tick();
        check("t5_pre_abort", 32'(cmp_valid), 32'd0);
        abort = 1'b1;
        job_valid = 1'b1; job_id = 4'd8; job_w_base = 8'h18; job_x_base = 8'h28; job_clear = 1'b0;
        tick();
        abort = 1'b0;
        job_valid = 1'b0;
        check_cmp("t5_cmp", 4'd4, 2'b10, 16'd5);
        check("t5_q_flushed", 32'(q_level), 32'd0);
        check("t5_not_idle",  32'(idle),    32'd0);
        accept("t5_accept");
        check("t5_idle",      32'(idle),    32'd1);
        for (int i = 0; i < 3; i++) begin
            check("t5_no_launch", 32'(eng_start), 32'd0);
            tick();
        end

        // Done arriving on the very cycle the watchdog would fire.
        push(4'd9, 8'h19, 8'h29, 1'b0);
        wait_start("t6_start");
        repeat (TIMEOUT) tick();
        check("t6_no_cmp_yet", 32'(cmp_valid), 32'd0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check_cmp("t6_cmp", 4'd9, 2'b00, 16'd1000);
        accept("t6_accept");

        // Asynchronous reset in the middle of a job.
        push(4'd10, 8'hA5, 8'h5A, 1'b1);
        wait_start("t6r_start");
        repeat (3) tick();
        check("t6r_w_base_live", 32'(eng_w_base), 32'hA5);
        rst = 1'b1;
        #1;
        check("t6r_strobes",  32'({eng_clear, eng_start, cmp_valid}), 32'd0);
        check("t6r_bases",    32'({eng_w_base, eng_x_base}), 32'd0);
        check("t6r_record",   32'({cmp_id, cmp_status, cmp_cycles}), 32'd0);
        check("t6r_q_level",  32'(q_level),   32'd0);
        check("t6r_idle",     32'(idle),      32'd1);
        check("t6r_ready",    32'(job_ready), 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6r_quiet", 32'({eng_start, eng_clear, cmp_valid}), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
